// File: rtl/title_pkg.sv
// Shared types and constants for the title-screen sequencer.
package title_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    SHOW = 3'd1,
    ACK  = 3'd2,
    FADE = 3'd3,
    DONE = 3'd4
  } title_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [3:0] FADE_FULL = 4'hF;

  function automatic int max_frames(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick from the vsync falling edge, and key press events from the
// zero-to-nonzero transition of the keycode.
module frame_tick_gen
  import title_pkg::*;
(
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic [7:0] keycode,
  output logic       frame_tick,
  output logic       press_evt
);

  logic       vsync_q;
  logic       primed;
  logic [7:0] key_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      vsync_q <= 1'b1;
      primed  <= 1'b0;
      key_q   <= KEY_NONE;
    end else begin
      vsync_q <= vsync;
      primed  <= 1'b1;
      key_q   <= keycode;
    end
  end

  // primed masks the first cycle after reset, so a vsync already low at
  // release is not mistaken for a falling edge.
  assign frame_tick = primed & vsync_q & ~vsync;
  assign press_evt  = (keycode != KEY_NONE) && (key_q == KEY_NONE);

endmodule

// File: rtl/title_screen_ctrl.sv
// Title-screen sequencer: boot delay, blinking prompt, start-key ack,
// 16-step fade-out and a one-cycle start_game pulse.
module title_screen_ctrl
  import title_pkg::*;
#(
  parameter int BOOT_FRAMES      = 60,
  parameter int BLINK_FRAMES     = 30,
  parameter int ACK_FRAMES       = 20,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vsync,
  input  logic [7:0] keycode,
  input  logic       restart,
  output logic       prompt_en,
  output logic       title_active,
  output logic [3:0] fade_level,
  output logic       start_game,
  output logic [2:0] state_dbg
);

  localparam int CNT_W =
    $clog2(max_frames(BOOT_FRAMES, BLINK_FRAMES, ACK_FRAMES, FADE_STEP_FRAMES)) + 1;

  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_FRAMES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(FADE_STEP_FRAMES - 1);

  title_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             armed;
  logic             frame_tick;
  logic             press_evt;

  frame_tick_gen u_frame_tick_gen (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .vsync      (vsync),
    .keycode    (keycode),
    .frame_tick (frame_tick),
    .press_evt  (press_evt)
  );

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state        <= BOOT;
      cnt          <= '0;
      phase        <= 1'b1;
      armed        <= 1'b0;
      prompt_en    <= 1'b0;
      title_active <= 1'b1;
      fade_level   <= FADE_FULL;
      start_game   <= 1'b0;
    end else begin
      // NOTE: defaults first; a later assignment to the same register in the
      // case below overrides them for this edge.
      start_game <= 1'b0;
      if (keycode == KEY_NONE) armed <= 1'b1;

      unique case (state)
        BOOT: begin
          if (frame_tick) begin
            if (cnt == BOOT_LAST) begin
              state     <= SHOW;
              cnt       <= '0;
              phase     <= 1'b1;
              prompt_en <= 1'b1;
              armed     <= (keycode == KEY_NONE);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        SHOW: begin
          // A press beats a coincident frame tick.
          if (press_evt && armed) begin
            state     <= ACK;
            cnt       <= '0;
            prompt_en <= 1'b1;
          end else if (frame_tick) begin
            if (cnt == BLINK_LAST) begin
              cnt       <= '0;
              phase     <= ~phase;
              prompt_en <= ~phase;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ACK: begin
          if (frame_tick) begin
            if (cnt == ACK_LAST) begin
              state <= FADE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        FADE: begin
          if (frame_tick) begin
            if (cnt == STEP_LAST) begin
              cnt <= '0;
              if (fade_level == 4'd0) begin
                state        <= DONE;
                prompt_en    <= 1'b0;
                title_active <= 1'b0;
                start_game   <= 1'b1;
              end else begin
                fade_level <= fade_level - 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          if (restart) begin
            state        <= BOOT;
            cnt          <= '0;
            phase        <= 1'b1;
            fade_level   <= FADE_FULL;
            title_active <= 1'b1;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/title_screen_ctrl.md
# title_screen_ctrl

Sequencer for the title-screen overlay layer. It counts video frames from the VGA controller's vsync and blinks the "press start" prompt. It accepts the start keypress from the keyboard path, fades the title layer out in 16 steps, and issues a one-cycle `start_game` pulse to the game FSM. It sits between the VGA controller and keyboard interface on the input side, and the title/prompt sprite units and colour mapper on the output side.

## Interface
- `BOOT_FRAMES`, 60: frames after reset before the prompt appears and keys are accepted.
- `BLINK_FRAMES`, 30: frames per prompt on/off half-period.
- `ACK_FRAMES`, 20: frames the prompt is held solid after the start key.
- `FADE_STEP_FRAMES`, 4: frames per fade level decrement.
- `vga_clk` input 1: pixel clock, all logic on rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `vsync` input 1: active-low vertical sync from the VGA controller, same clock domain.
- `keycode` input 8: current USB keycode; 0 means no key.
- `restart` input 1: level; returns the block from DONE to BOOT.
- `prompt_en` output 1: ANDed with the prompt sprite's `on`.
- `title_active` output 1: title layer owns the screen.
- `fade_level` output 4: 15 is full brightness, 0 is black. The colour mapper scales title RGB by it.
- `start_game` output 1: one-cycle pulse.
- `state_dbg` output 3: current state encoding, for hex display.

## Operation
- Frame tick: one-cycle pulse on the vsync falling edge, detected with a registered copy of `vsync` that resets to 1.
- Key press event: `keycode != 0` this cycle and `keycode == 0` last cycle. The registered keycode resets to 0.
- Arm flag: cleared on entry to SHOW if `keycode != 0`; set once `keycode == 0` is sampled. Press events count only while armed, so a key held through BOOT never starts the game.
- One frame counter is shared by all states. It clears on every state transition and increments on each frame tick.
- States:
  - BOOT: `prompt_en=0`. After `BOOT_FRAMES` ticks, go to SHOW. Key presses are ignored.
  - SHOW: `prompt_en` = blink phase. Phase starts at 1 on entry and toggles each `BLINK_FRAMES` ticks, and the counter clears on each toggle. An armed press event goes to ACK.
  - ACK: `prompt_en=1`. After `ACK_FRAMES` ticks, go to FADE. Further keys are ignored.
  - FADE: `prompt_en=1`. Every `FADE_STEP_FRAMES` ticks, `fade_level` decrements. The tick that would take it below 0 goes to DONE instead, so level 0 is held for one full step.
  - DONE: `prompt_en=0`, `title_active=0`, `fade_level=0`. `start_game` is asserted for exactly the first cycle in DONE. `restart=1` goes to BOOT and restores `fade_level=15`.
- `title_active=1` in every state except DONE.
- Counter width is `$clog2` of the largest parameter plus 1. Compares are `==` against `param-1` at a tick, so exactly N ticks elapse per phase.

## Timing
- Reset values: state BOOT, `prompt_en=0`, `title_active=1`, `fade_level=15`, `start_game=0`, counter 0, blink phase 1, arm flag 0. `Reset` asserted mid-fade returns all of these immediately and asynchronously.
- All outputs are registered. A press event at cycle t makes state ACK visible at t+1. `prompt_en` is already 1 then, even if the blink phase was 0.
- A frame tick and a press event in the same SHOW cycle: the press wins, and the state moves to ACK with the counter cleared.
- `restart` in any state other than DONE: ignored.
- `restart` held high on entry to DONE: `start_game` still pulses for one cycle, and BOOT is entered on the next cycle.
- A `vsync` low at reset release does not create a tick; only a 1→0 transition does.

## Structure
- Shared package `title_pkg`:
  - `title_state_t` enum: BOOT=0, SHOW=1, ACK=2, FADE=3, DONE=4.
  - `KEY_NONE = 8'h00` constant.
- One sub-module, `frame_tick_gen`: vsync edge detect plus key press-event detect. The FSM and counter stay in the top.

## Test plan
- Reset, then 60 vsync frames: `prompt_en` rises exactly at tick 60. It then toggles every 30 ticks, and `state_dbg` reads 1.
- `keycode=8'h28` held from reset through BOOT: no ACK. Release to 0 and press again: ACK on the cycle after the press, with `prompt_en=1`.
- Press during SHOW with the prompt off, on the same cycle as a vsync fall: state goes to ACK, `prompt_en=1` next cycle, counter 0.
- Full sequence: after 20 ACK frames, `fade_level` steps 15→0 every 4 frames (64 frames total). `start_game` is high for exactly one cycle, and `title_active` falls on that cycle.
- `Reset` pulsed when `fade_level=7`: `fade_level=15`, `prompt_en=0`, state BOOT, asynchronously with no clock edge needed.
- In DONE, pulse `restart`: state returns to BOOT, `fade_level=15`, `title_active=1`. No second `start_game` pulse appears.
